// File: rtl/guess_pkg.sv
// Shared types and constants for the ENTER button conditioning path.
package guess_pkg;

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_CHK = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int GLITCH_CNT_W            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/enter_debounce.sv
// ENTER push-button conditioner: synchronise, normalise polarity, debounce.
// Define ENTER_DEBOUNCE_GLITCH_CNT_EN to add the saturating o_glitch_cnt port.
module enter_debounce
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_button_raw,
  output logic o_enter,
  output logic o_press,
  output logic o_release
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_q, enter_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             abort;
  logic             pin_sync;
  logic             s;

  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW_IN)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (i_button_raw),
    .q_o     (pin_sync)
  );

  assign s = pin_sync ^ ACTIVE_LOW_IN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (s) begin
          state_d = S_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!s) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!s) begin
          state_d = S_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      S_RELEASE_CHK: begin
        if (s) begin
          state_d = S_HELD;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
    // Decoding the next state keeps o_enter registered yet aligned with the state.
    enter_d = (state_d == S_HELD) || (state_d == S_RELEASE_CHK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      enter_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      enter_q   <= enter_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_enter   = enter_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != '1)) begin
      glitch_q <= glitch_q + GLITCH_CNT_W'(1);
    end
  end

  assign o_glitch_cnt = glitch_q;
`else
  logic abort_unused;
  assign abort_unused = abort;
`endif

endmodule

// File: tb/tb_enter_debounce.sv
// Scoreboarded bench for enter_debounce with DEBOUNCE_CYCLES=4, active-low pin.
module tb_enter_debounce;

  logic clk;
  logic reset_n;
  logic i_button_raw;
  logic o_enter;
  logic o_press;
  logic o_release;
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] o_glitch_cnt;
  int         exp_glitch;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit is_press;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  enter_debounce #(
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW_IN   (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_button_raw (i_button_raw),
    .o_enter      (o_enter),
    .o_press      (o_press),
    .o_release    (o_release)
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    ,
    .o_glitch_cnt (o_glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every pulse the DUT presents must match the next expected event.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (o_press && o_release) begin
          checks++;
          failures++;
          $display("FAIL both_pulses cyc=%0d press=1 release=1 required at most one", cyc);
        end
        if (o_press || o_release) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d press=%0d release=%0d required none",
                     cyc, o_press, o_release);
          end else begin
            ev = exp_q.pop_front();
            if ((o_press != ev.is_press) || (cyc != ev.cyc)) begin
              failures++;
              $display("FAIL pulse actual press=%0d cyc=%0d required press=%0d cyc=%0d",
                       o_press, cyc, ev.is_press, ev.cyc);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input bit p, input int c);
    ev_t ev;
    ev.is_press = p;
    ev.cyc      = c;
    exp_q.push_back(ev);
  endtask

  initial begin
    int n;
    bit pat[5];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    exp_glitch = 0;
`endif
    i_button_raw = 1'b1;
    reset_n      = 1'b0;
    step(2);
    chk("reset_enter", o_enter, 0);
    chk("reset_press", o_press, 0);
    chk("reset_release", o_release, 0);
    reset_n = 1'b1;
    step(3);

    // Clean press
    i_button_raw = 1'b0;
    n = cyc;
    push(1'b1, n + 7);
    wait_until(n + 6);
    chk("press_before_latency", o_enter, 0);
    wait_until(n + 7);
    chk("press_at_latency", o_enter, 1);
    step(3);
    chk("press_held", o_enter, 1);

    // Bounce on release: two-cycle high glitch
    i_button_raw = 1'b1;
    step(2);
    i_button_raw = 1'b0;
    step(10);
    chk("release_bounce_level", o_enter, 1);
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    exp_glitch++;
    chk("release_bounce_glitch", o_glitch_cnt, exp_glitch);
`endif

    // Clean release
    i_button_raw = 1'b1;
    n = cyc;
    push(1'b0, n + 7);
    wait_until(n + 6);
    chk("release_before_latency", o_enter, 1);
    wait_until(n + 7);
    chk("release_at_latency", o_enter, 0);
    step(3);

    // Bounce on press
    for (int i = 0; i < 5; i++) begin
      i_button_raw = pat[i];
      step(1);
      chk("press_bounce_level", o_enter, 0);
    end
    i_button_raw = 1'b0;
    n = cyc;
    push(1'b1, n + 7);
    wait_until(n + 6);
    chk("bounce_press_before_latency", o_enter, 0);
    wait_until(n + 7);
    chk("bounce_press_at_latency", o_enter, 1);
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    exp_glitch += 2;
    chk("press_bounce_glitch", o_glitch_cnt, exp_glitch);
`endif
    step(2);

    i_button_raw = 1'b1;
    n = cyc;
    push(1'b0, n + 7);
    wait_until(n + 7);
    chk("release2_at_latency", o_enter, 0);
    step(3);

    // Reset two cycles into the press check
    i_button_raw = 1'b0;
    n = cyc;
    wait_until(n + 5);
    reset_n = 1'b0;
    #1;
    chk("midreset_enter", o_enter, 0);
    chk("midreset_press", o_press, 0);
    chk("midreset_release", o_release, 0);
`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    exp_glitch = 0;
    chk("midreset_glitch", o_glitch_cnt, exp_glitch);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    n = cyc;
    push(1'b1, n + 7);
    wait_until(n + 6);
    chk("post_reset_before_latency", o_enter, 0);
    wait_until(n + 7);
    chk("post_reset_at_latency", o_enter, 1);
    step(2);

    i_button_raw = 1'b1;
    n = cyc;
    push(1'b0, n + 7);
    wait_until(n + 8);
    chk("release3_done", o_enter, 0);
    step(2);

`ifdef ENTER_DEBOUNCE_GLITCH_CNT_EN
    // Glitch counter saturation
    repeat (300) begin
      i_button_raw = 1'b0;
      step(1);
      i_button_raw = 1'b1;
      step(2);
    end
    step(6);
    chk("glitch_saturated", o_glitch_cnt, 255);
    chk("saturation_level", o_enter, 0);
    i_button_raw = 1'b0;
    step(1);
    i_button_raw = 1'b1;
    step(6);
    chk("glitch_holds", o_glitch_cnt, 255);
`endif

    step(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
